// File: rtl/dmem_pkg.sv
// dmem_pkg: shared load/store type codes, access sizes, FSM state encoding and byte-lane enable constants
package dmem_pkg;
  localparam logic [2:0] LD_NONE = 3'd0, LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3, LD_LBU = 3'd4, LD_LHU = 3'd5;
  localparam logic [2:0] ST_NONE = 3'd0, ST_SB = 3'd1, ST_SH = 3'd2, ST_SW = 3'd3, ST_SB_ALT = 3'd4, ST_SH_ALT = 3'd5;
  localparam logic [1:0] SZ_NONE = 2'd0, SZ_B = 2'd1, SZ_H = 2'd2, SZ_W = 2'd3;
  localparam logic [3:0] BE_NONE = 4'b0000, BE_B0 = 4'b0001, BE_HLO = 4'b0011, BE_HHI = 4'b1100, BE_W = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;
  function automatic logic [1:0] st_size(input logic [2:0] t);
    return (t == ST_SB || t == ST_SB_ALT) ? SZ_B : (t == ST_SH || t == ST_SH_ALT) ? SZ_H : t == ST_SW ? SZ_W : SZ_NONE;
  endfunction
  function automatic logic [1:0] ld_size(input logic [2:0] t);
    return (t == LD_LB || t == LD_LBU) ? SZ_B : (t == LD_LH || t == LD_LHU) ? SZ_H : t == LD_LW ? SZ_W : SZ_NONE;
  endfunction
endpackage

// File: rtl/dmem_load_extend.sv
// dmem_load_extend: picks byte/half of word by off and sign/zero-extends per ltype (ports: ltype, off, word in; data out)
module dmem_load_extend
  import dmem_pkg::*;
(
  input  logic [2:0]  ltype,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = off == 2'd0 ? word[7:0] : off == 2'd1 ? word[15:8] : off == 2'd2 ? word[23:16] : word[31:24];
    h = off[1] ? word[31:16] : word[15:0];
    data = ltype == LD_LB  ? {{24{b[7]}}, b} :
           ltype == LD_LBU ? {24'd0, b} :
           ltype == LD_LH  ? {{16{h[15]}}, h} :
           ltype == LD_LHU ? {16'd0, h} :
           ltype == LD_LW  ? word : 32'd0;
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store FSM (CLK, RESET, LOAD_TYPE, STORE_TYPE, ADDR, WDATA, MEM_RDATA, MEM_BUSYWAIT in; BUSYWAIT, RDATA, ERR, MEM_READ/WRITE/ADDR/WDATA/BYTE_EN out); define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  LOAD_TYPE,
  input  logic [2:0]  STORE_TYPE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        BUSYWAIT,
  output logic [31:0] RDATA,
  output logic        ERR,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BYTE_EN,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_BUSYWAIT
);
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
  state_e      state_q, state_d;
  logic [1:0]  st_q, st_d;
  logic [2:0]  ld_q, ld_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  req_st, req_ld, req_sz, acc_sz;
  logic [31:0] req_addr, ext;
  logic        req, mis, acc;
  assign req_st = st_size(STORE_TYPE);
  assign req_ld = ld_size(LOAD_TYPE);
  assign req_sz = req_st != SZ_NONE ? req_st : req_ld;
  assign req = req_sz != SZ_NONE;
  assign req_addr = req_sz == SZ_W ? {ADDR[31:2], 2'b00} : req_sz == SZ_H ? {ADDR[31:1], 1'b0} : ADDR;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = (req_sz == SZ_H && ADDR[0]) || (req_sz == SZ_W && ADDR[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  dmem_load_extend u_ext (.ltype(ld_q), .off(addr_q[1:0]), .word(MEM_RDATA), .data(ext));
  always_comb begin
    state_d = state_q;
    st_d = st_q;
    ld_d = ld_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (req) begin
        st_d = req_st;
        ld_d = req_st != SZ_NONE ? LD_NONE : LOAD_TYPE;
        addr_d = req_addr;
        wdata_d = WDATA;
        cnt_d = 8'd0;
        rdata_d = 32'd0;
        err_d = mis;
        state_d = mis ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        cnt_d = (!MEM_BUSYWAIT || cnt_q == TO_LAST) ? 8'd0 : cnt_q + 8'd1;
        rdata_d = MEM_BUSYWAIT ? 32'd0 : ext;
        err_d = MEM_BUSYWAIT && cnt_q == TO_LAST;
        state_d = (!MEM_BUSYWAIT || cnt_q == TO_LAST) ? S_DONE : S_ACCESS;
      end
      default: begin
        err_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      st_q <= SZ_NONE;
      ld_q <= LD_NONE;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q <= 8'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q <= st_d;
      ld_q <= ld_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign acc = state_q == S_ACCESS;
  assign acc_sz = st_q != SZ_NONE ? st_q : ld_size(ld_q);
  assign BUSYWAIT = !RESET && (acc || (state_q == S_IDLE && req));
  assign MEM_READ = acc && ld_q != LD_NONE;
  assign MEM_WRITE = acc && st_q != SZ_NONE;
  assign MEM_ADDR = {addr_q[31:2], 2'b00};
  assign MEM_WDATA = st_q == SZ_B ? {4{wdata_q[7:0]}} : st_q == SZ_H ? {2{wdata_q[15:0]}} : wdata_q;
  assign MEM_BYTE_EN = !acc ? BE_NONE : acc_sz == SZ_B ? BE_B0 << addr_q[1:0] :
                       acc_sz == SZ_H ? (addr_q[1] ? BE_HHI : BE_HLO) : acc_sz == SZ_W ? BE_W : BE_NONE;
  assign RDATA = state_q == S_DONE ? rdata_q : 32'd0;
  assign ERR = state_q == S_DONE && err_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: table-driven directed check of dmem_access_ctrl with MEM_TIMEOUT=4 plus reset and no-op sequences
module tb_dmem_access_ctrl;
  import dmem_pkg::*;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic [2:0]  LOAD_TYPE = 3'd0, STORE_TYPE = 3'd0;
  logic [31:0] ADDR = 32'd0, WDATA = 32'd0, MEM_RDATA = 32'd0;
  logic        MEM_BUSYWAIT = 1'b0;
  logic        BUSYWAIT, ERR, MEM_READ, MEM_WRITE;
  logic [31:0] RDATA, MEM_ADDR, MEM_WDATA;
  logic [3:0]  MEM_BYTE_EN;
  int checks = 0, errors = 0;
  dmem_access_ctrl #(.MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD_TYPE(LOAD_TYPE), .STORE_TYPE(STORE_TYPE), .ADDR(ADDR), .WDATA(WDATA),
    .BUSYWAIT(BUSYWAIT), .RDATA(RDATA), .ERR(ERR), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_BYTE_EN(MEM_BYTE_EN), .MEM_RDATA(MEM_RDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [2:0]  ld, st;
    logic [31:0] addr, wdata, mrdata;
    int          nwait;
    logic [3:0]  be;
    logic [31:0] maddr, mwdata, rdata;
    logic        rd, wr, err;
    int          busy, acc;
  } vec_t;
  vec_t tv [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input int idx, input vec_t v);
    int busy = 0, acc = 0;
    logic done = 1'b0, seen = 1'b0;
    logic [3:0] be = 4'd0;
    logic [31:0] maddr = 32'd0, mwdata = 32'd0, rdata = 32'd0;
    logic rd = 1'b0, wr = 1'b0, err = 1'b0;
    LOAD_TYPE = v.ld;
    STORE_TYPE = v.st;
    ADDR = v.addr;
    WDATA = v.wdata;
    MEM_RDATA = v.mrdata;
    MEM_BUSYWAIT = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      #1;
      if (BUSYWAIT) busy++;
      if (c > 0 && !BUSYWAIT) begin
        rdata = RDATA;
        err = ERR;
        done = 1'b1;
      end
      if (MEM_READ || MEM_WRITE) begin
        acc++;
        if (!seen) begin
          seen = 1'b1;
          be = MEM_BYTE_EN;
          maddr = MEM_ADDR;
          mwdata = MEM_WDATA;
          rd = MEM_READ;
          wr = MEM_WRITE;
        end
        MEM_BUSYWAIT = acc <= v.nwait;
      end
      if (c == 1) begin
        LOAD_TYPE = 3'd0;
        STORE_TYPE = 3'd0;
      end
      @(negedge CLK);
    end
    if (!done) chk($sformatf("v%0d done_bound", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d busy_cycles", idx), 32'(busy), 32'(v.busy));
    chk($sformatf("v%0d access_cycles", idx), 32'(acc), 32'(v.acc));
    chk($sformatf("v%0d byte_en", idx), 32'(be), 32'(v.be));
    chk($sformatf("v%0d mem_addr", idx), maddr, v.maddr);
    chk($sformatf("v%0d mem_wdata", idx), mwdata, v.mwdata);
    chk($sformatf("v%0d rd_wr", idx), {30'd0, rd, wr}, {30'd0, v.rd, v.wr});
    chk($sformatf("v%0d rdata", idx), rdata, v.rdata);
    chk($sformatf("v%0d err", idx), 32'(err), 32'(v.err));
    #1;
    chk($sformatf("v%0d after_done", idx), {29'd0, ERR, BUSYWAIT, MEM_READ | MEM_WRITE}, 32'd0);
    MEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
  endtask
  initial begin
    tv[0]  = '{ST_NONE, ST_NONE, 32'h100, 32'hDEADBEEF, 32'h0, 0, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0, 2, 1};
    tv[0].st = ST_SW;
    tv[1]  = '{LD_NONE, ST_SB, 32'h203, 32'h000000A5, 32'h0, 3, 4'h8, 32'h200, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 1'b0, 5, 4};
    tv[2]  = '{LD_LB, ST_NONE, 32'h101, 32'h0, 32'h00008000, 0, 4'h2, 32'h100, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 2, 1};
    tv[3]  = '{LD_LBU, ST_NONE, 32'h101, 32'h0, 32'h00008000, 0, 4'h2, 32'h100, 32'h0, 32'h00000080, 1'b1, 1'b0, 1'b0, 2, 1};
    tv[4]  = '{LD_LH, ST_NONE, 32'h102, 32'h0, 32'h80011234, 0, 4'hC, 32'h100, 32'h0, 32'hFFFF8001, 1'b1, 1'b0, 1'b0, 2, 1};
    tv[5]  = '{LD_LHU, ST_NONE, 32'h100, 32'h0, 32'h8001F234, 0, 4'h3, 32'h100, 32'h0, 32'h0000F234, 1'b1, 1'b0, 1'b0, 2, 1};
    tv[6]  = '{LD_LW, ST_NONE, 32'h104, 32'h0, 32'hCAFEF00D, 1, 4'hF, 32'h104, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 3, 2};
    tv[7]  = '{LD_NONE, ST_SH_ALT, 32'h206, 32'h1234ABCD, 32'h0, 0, 4'hC, 32'h204, 32'hABCDABCD, 32'h0, 1'b0, 1'b1, 1'b0, 2, 1};
    tv[8]  = '{LD_LW, ST_SB_ALT, 32'h001, 32'h00000077, 32'hFFFFFFFF, 0, 4'h2, 32'h0, 32'h77777777, 32'h0, 1'b0, 1'b1, 1'b0, 2, 1};
    tv[9]  = '{LD_LW, ST_NONE, 32'h300, 32'h0, 32'h11111111, 99, 4'hF, 32'h300, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5, 4};
`ifdef DMEM_MISALIGN_TRAP_EN
    tv[10] = '{LD_LW, ST_NONE, 32'h102, 32'h0, 32'h89ABCDEF, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1, 0};
    tv[11] = '{LD_NONE, ST_SH, 32'h103, 32'h0000BEEF, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1, 0};
`else
    tv[10] = '{LD_LW, ST_NONE, 32'h102, 32'h0, 32'h89ABCDEF, 0, 4'hF, 32'h100, 32'h0, 32'h89ABCDEF, 1'b1, 1'b0, 1'b0, 2, 1};
    tv[11] = '{LD_NONE, ST_SH, 32'h103, 32'h0000BEEF, 32'h0, 0, 4'hC, 32'h100, 32'hBEEFBEEF, 32'h0, 1'b0, 1'b1, 1'b0, 2, 1};
`endif
    LOAD_TYPE = LD_LW;
    STORE_TYPE = ST_SW;
    ADDR = 32'h44;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_busywait", 32'(BUSYWAIT), 32'd0);
    chk("reset_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
    chk("reset_byte_en", 32'(MEM_BYTE_EN), 32'd0);
    chk("reset_err_rdata", RDATA | 32'(ERR), 32'd0);
    chk("reset_mem_addr", MEM_ADDR, 32'd0);
    LOAD_TYPE = 3'd0;
    STORE_TYPE = 3'd0;
    RESET = 1'b0;
    @(negedge CLK);
    LOAD_TYPE = 3'd6;
    STORE_TYPE = 3'd7;
    #1;
    chk("noop_busywait_now", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
    #1;
    chk("noop_next_cycle", {30'd0, BUSYWAIT, MEM_READ | MEM_WRITE}, 32'd0);
    LOAD_TYPE = 3'd0;
    STORE_TYPE = 3'd0;
    @(negedge CLK);
    for (int i = 0; i < 12; i++) run(i, tv[i]);
    STORE_TYPE = ST_SW;
    ADDR = 32'h40;
    WDATA = 32'h12345678;
    MEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    STORE_TYPE = 3'd0;
    #1;
    chk("rst_mid_write_before", 32'(MEM_WRITE), 32'd1);
    #1 RESET = 1'b1;
    #1;
    chk("rst_mid_write_drop", 32'(MEM_WRITE), 32'd0);
    chk("rst_mid_busywait", 32'(BUSYWAIT), 32'd0);
    chk("rst_mid_byte_en", 32'(MEM_BYTE_EN), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    MEM_BUSYWAIT = 1'b0;
    #1;
    chk("rst_mid_idle", {30'd0, BUSYWAIT, MEM_WRITE}, 32'd0);
    @(negedge CLK);
    run(12, tv[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 64, max ACCESS cycles before abort (range 2..255).
REQ-002 SHALL provide port CLK  input  1  sole clock, rising edge.
REQ-003 SHALL provide port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port LOAD_TYPE  input  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6-7 none.
REQ-005 SHALL provide port STORE_TYPE  input  3  0 none, 1/4 SB, 2/5 SH, 3 SW, 6-7 none.
REQ-006 SHALL provide port ADDR  input  32  byte address from ALU.
REQ-007 SHALL provide port WDATA  input  32  store data, rs2.
REQ-008 SHALL provide port BUSYWAIT  output  1  pipeline stall request.
REQ-009 SHALL provide port RDATA  output  32  extended load result, valid in DONE.
REQ-010 SHALL provide port ERR  output  1  one-cycle access-fault pulse.
REQ-011 SHALL provide ports MEM_READ, MEM_WRITE  output  1 each  memory strobes.
REQ-012 SHALL provide port MEM_ADDR  output  32  word address, bits[1:0]=0.
REQ-013 SHALL provide port MEM_WDATA  output  32  lane-shifted store data.
REQ-014 SHALL provide port MEM_BYTE_EN  output  4  byte lane enables.
REQ-015 SHALL provide ports MEM_RDATA  input  32 and MEM_BUSYWAIT  input  1  memory response.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-017 IDLE: nonzero request SHALL drive BUSYWAIT combinationally high same cycle and latch type, ADDR, WDATA at next edge, entering ACCESS.
REQ-018 Load and store both nonzero in IDLE: store SHALL take precedence; load ignored.
REQ-019 ACCESS: MEM_READ or MEM_WRITE SHALL be high, with MEM_ADDR/MEM_WDATA/MEM_BYTE_EN driven from latched values only.
REQ-020 ACCESS SHALL exit to DONE at the first edge sampling MEM_BUSYWAIT low; MEM_RDATA captured at that edge.
REQ-021 DONE: BUSYWAIT low, strobes low, RDATA valid for exactly one cycle; requests ignored; next state IDLE.
REQ-022 Minimum latency: request at cycle n, BUSYWAIT high cycles n and n+1, low in DONE at n+2.
REQ-023 Byte lanes: SB enable 1<<ADDR[1:0], data byte replicated to all lanes; SH enable 0011 or 1100 by ADDR[1]; SW 1111.
REQ-024 Load extract: select byte/half by ADDR[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-025 Saturating cycle counter in ACCESS; on reaching MEM_TIMEOUT, SHALL drop strobes, enter DONE with ERR=1 and RDATA=0.
REQ-026 Reset asserted mid-ACCESS SHALL drop strobes immediately, discarding the access.

Reset
REQ-027 RESET SHALL force IDLE, counter 0, latched registers 0, RDATA 0, ERR 0, MEM_READ/MEM_WRITE 0, MEM_BYTE_EN 0000.
REQ-028 While RESET is high, BUSYWAIT SHALL be 0 regardless of request inputs.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN defined: misaligned access (LH/LHU/SH with ADDR[0]=1; LW/SW with ADDR[1:0]!=0) SHALL skip ACCESS, go IDLE -> DONE with ERR=1, no strobes.
REQ-030 Macro undefined: misaligned offset bits SHALL be cleared to the natural alignment and the access proceeds; ERR only from timeout.

Structure
REQ-031 Package dmem_pkg SHALL hold load/store type codes, FSM state encoding and lane-enable constants.
REQ-032 Sub-module dmem_load_extend SHALL implement REQ-024 combinationally; FSM, counter and store lane logic stay in dmem_access_ctrl.

Verification
REQ-033 SW ADDR=0x100 WDATA=0xDEADBEEF, MEM_BUSYWAIT low -> MEM_BYTE_EN=1111, MEM_ADDR=0x100, BUSYWAIT high 2 cycles.
REQ-034 SB ADDR=0x203 WDATA=0x000000A5, MEM_BUSYWAIT high 3 cycles -> MEM_BYTE_EN=1000, MEM_WDATA=0xA5A5A5A5, BUSYWAIT high 5 cycles.
REQ-035 LB ADDR=0x0x1 with MEM_RDATA=0x00008000... use ADDR=0x101 MEM_RDATA=0x00008000 -> RDATA=0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 MEM_BUSYWAIT stuck high, MEM_TIMEOUT=4 -> strobes drop after 4 ACCESS cycles, ERR pulse, RDATA=0.
REQ-037 LW ADDR=0x102: with macro -> ERR, no MEM_READ; without -> MEM_ADDR=0x100, normal completion.
REQ-038 RESET pulsed during ACCESS -> MEM_WRITE low same cycle, IDLE, BUSYWAIT low.
